// File: rtl/mac_pkg.sv
// Shared types and default widths for the serial MAC sequencer and its serializer.
package mac_pkg;

  localparam int unsigned OP_W_DEF  = 8;
  localparam int unsigned RES_W_DEF = 20;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    SHIFT,
    ISSUE,
    WAIT,
    CAPTURE,
    DRAIN,
    DONE
  } mac_seq_state_e;

  // {carry, result} word as it leaves the accumulator at default widths
  typedef struct packed {
    logic                 carry;
    logic [RES_W_DEF-1:0] res;
  } mac_word_t;

endpackage

// File: rtl/mac_piso.sv
// Parallel-load, right-shift serializer; emits bit 0 first while shift_i is high.
module mac_piso
  import mac_pkg::*;
#(
  parameter int unsigned W = RES_W_DEF + 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic         shift_i,
  input  logic [W-1:0] data_i,
  output logic         ser_o,
  output logic         valid_o
);

  logic [W-1:0] shreg_q, shreg_d;

  always_comb begin
    shreg_d = shreg_q;
    if (load_i) begin
      shreg_d = data_i;
    end else if (shift_i) begin
      shreg_d = shreg_q >> 1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shreg_q <= '0;
    end else begin
      shreg_q <= shreg_d;
    end
  end

  // Serial line is held low whenever it is not carrying data.
  assign valid_o = shift_i;
  assign ser_o   = shift_i & shreg_q[0];

endmodule

// File: rtl/mac_serial_sequencer.sv
// Serial-host controller for the 8x8 MAC datapath: clear, per-term load/issue/wait,
// then serialize {carry, result} and pulse finish.
module mac_serial_sequencer
  import mac_pkg::*;
#(
  parameter int unsigned OP_W    = OP_W_DEF,
  parameter int unsigned RES_W   = RES_W_DEF,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] num_terms,
  input  logic             ser_a,
  input  logic             ser_b,
  output logic [OP_W-1:0]  op_a,
  output logic [OP_W-1:0]  op_b,
  output logic             acc_clear,
  output logic             mac_start,
  input  logic             mac_done,
  input  logic [RES_W-1:0] mac_res,
  input  logic             mac_carry,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             finish,
  output logic             err_timeout
);

  localparam int unsigned BitW = (OP_W > 1) ? $clog2(OP_W) : 1;
  localparam int unsigned DrnW = (RES_W > 0) ? $clog2(RES_W + 1) : 1;
  localparam int unsigned WdW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned TrmW = CNT_W + 1;

  localparam logic [BitW-1:0] BitLast  = BitW'(OP_W - 1);
  localparam logic [DrnW-1:0] DrnLast  = DrnW'(RES_W);
  localparam logic [WdW-1:0]  WdLast   = WdW'(TIMEOUT - 1);
  localparam logic [TrmW-1:0] TermsMax = TrmW'(2 ** CNT_W);

  mac_seq_state_e  state_q, state_d;
  logic [BitW-1:0] bit_cnt_q, bit_cnt_d;
  logic [DrnW-1:0] drn_cnt_q, drn_cnt_d;
  logic [WdW-1:0]  wd_cnt_q, wd_cnt_d;
  logic [TrmW-1:0] term_rem_q, term_rem_d;
  logic [OP_W-1:0] op_a_q, op_a_d;
  logic [OP_W-1:0] op_b_q, op_b_d;
  logic            err_q, err_d;
  logic            piso_load, piso_shift;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    drn_cnt_d  = drn_cnt_q;
    wd_cnt_d   = wd_cnt_q;
    term_rem_d = term_rem_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    err_d      = 1'b0;
    piso_load  = 1'b0;
    piso_shift = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          term_rem_d = (num_terms == '0) ? TermsMax : TrmW'(num_terms);
          state_d    = CLEAR;
        end
      end
      CLEAR: begin
        bit_cnt_d = '0;
        state_d   = SHIFT;
      end
      SHIFT: begin
        op_a_d    = OP_W'({ser_a, op_a_q} >> 1);
        op_b_d    = OP_W'({ser_b, op_b_q} >> 1);
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (bit_cnt_q == BitLast) begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        wd_cnt_d = '0;
        state_d  = WAIT;
      end
      WAIT: begin
        wd_cnt_d = wd_cnt_q + 1'b1;
        // Completion takes priority over a watchdog expiring on the same cycle.
        if (mac_done) begin
          term_rem_d = term_rem_q - 1'b1;
          bit_cnt_d  = '0;
          state_d    = (term_rem_d != '0) ? SHIFT : CAPTURE;
        end else if (wd_cnt_q == WdLast) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      CAPTURE: begin
        piso_load = 1'b1;
        drn_cnt_d = '0;
        state_d   = DRAIN;
      end
      DRAIN: begin
        piso_shift = 1'b1;
        drn_cnt_d  = drn_cnt_q + 1'b1;
        if (drn_cnt_q == DrnLast) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      drn_cnt_q  <= '0;
      wd_cnt_q   <= '0;
      term_rem_q <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      drn_cnt_q  <= drn_cnt_d;
      wd_cnt_q   <= wd_cnt_d;
      term_rem_q <= term_rem_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      err_q      <= err_d;
    end
  end

  mac_piso #(
    .W(RES_W + 1)
  ) u_piso (
    .clk_i  (clock),
    .rst_i  (reset),
    .load_i (piso_load),
    .shift_i(piso_shift),
    .data_i ({mac_carry, mac_res}),
    .ser_o  (ser_out),
    .valid_o(ser_valid)
  );

  assign op_a        = op_a_q;
  assign op_b        = op_b_q;
  assign acc_clear   = (state_q == CLEAR);
  assign mac_start   = (state_q == ISSUE);
  assign busy        = (state_q != IDLE);
  assign finish      = (state_q == DONE);
  assign err_timeout = err_q;

endmodule

// File: tb/tb_mac_serial_sequencer.sv
// Randomized self-checking bench: a timeline model of the host protocol and MAC datapath
// predicts every output each cycle; literal results pin the model.
module tb_mac_serial_sequencer;

  localparam int OP_W    = 8;
  localparam int RES_W   = 20;
  localparam int TIMEOUT = 64;
  localparam int CNT_W   = 4;

  logic             clock = 1'b0;
  logic             reset, start, ser_a, ser_b, mac_done, mac_carry;
  logic [CNT_W-1:0] num_terms;
  logic [RES_W-1:0] mac_res;
  logic [OP_W-1:0]  op_a, op_b;
  logic             acc_clear, mac_start, ser_out, ser_valid, busy, finish, err_timeout;

  always #5 clock = ~clock;

  mac_serial_sequencer #(
    .OP_W(OP_W), .RES_W(RES_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .num_terms(num_terms),
    .ser_a(ser_a), .ser_b(ser_b), .op_a(op_a), .op_b(op_b),
    .acc_clear(acc_clear), .mac_start(mac_start), .mac_done(mac_done),
    .mac_res(mac_res), .mac_carry(mac_carry), .ser_out(ser_out), .ser_valid(ser_valid),
    .busy(busy), .finish(finish), .err_timeout(err_timeout)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic chk_en = 1'b0;

  // Expected outputs for the cycle currently in progress
  logic            e_clr, e_ms, e_sv, e_so, e_busy, e_fin, e_err;
  logic [OP_W-1:0] e_a, e_b;
  logic [OP_W-1:0] cur_a, cur_b;

  // Model datapath state and per-term stimulus
  logic [RES_W:0]  acc;
  logic [OP_W-1:0] opa_t [16];
  logic [OP_W-1:0] opb_t [16];
  int              lat_t [16];

  // Observed event times and captured serial word
  int            clr_cyc, fin_cyc, iss_cyc, err_cyc, ser_idx, issue_cnt;
  logic [RES_W:0] ser_word;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (chk_en) begin
      checks++;
      if ({acc_clear, mac_start, op_a, op_b, ser_valid, ser_out, busy, finish, err_timeout} !==
          {e_clr, e_ms, e_a, e_b, e_sv, e_so, e_busy, e_fin, e_err}) begin
        errors++;
        $display("FAIL outputs cycle %0d: got clr=%b ms=%b a=%h b=%h sv=%b so=%b busy=%b fin=%b err=%b ; want clr=%b ms=%b a=%h b=%h sv=%b so=%b busy=%b fin=%b err=%b",
                 cyc, acc_clear, mac_start, op_a, op_b, ser_valid, ser_out, busy, finish,
                 err_timeout, e_clr, e_ms, e_a, e_b, e_sv, e_so, e_busy, e_fin, e_err);
      end
      if (acc_clear) begin
        clr_cyc   = cyc;
        ser_idx   = 0;
        issue_cnt = 0;
      end
      if (mac_start) begin
        iss_cyc = cyc;
        issue_cnt++;
      end
      if (finish) fin_cyc = cyc;
      if (err_timeout) err_cyc = cyc;
      if (ser_valid && ser_idx <= RES_W) begin
        ser_word[ser_idx] = ser_out;
        ser_idx++;
      end
    end
  end

  task automatic check_eq(input string name, input longint got, input longint want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic exp_idle();
    e_clr = 0; e_ms = 0; e_sv = 0; e_so = 0; e_busy = 0; e_fin = 0; e_err = 0;
    e_a = cur_a; e_b = cur_b;
    ser_a = 1'($urandom); ser_b = 1'($urandom);
  endtask

  task automatic exp_busy();
    exp_idle();
    e_busy = 1;
  endtask

  // Operand register after k LSB-first bits of nw have been shifted in over prev.
  function automatic logic [OP_W-1:0] part(input logic [OP_W-1:0] prev, input logic [OP_W-1:0] nw,
                                           input int k);
    logic [2*OP_W-1:0] both;
    both = {nw, prev};
    return OP_W'(both >> k);
  endfunction

  task automatic run_session(input int n, input bit force_cap, input int rst_drain,
                             input int to_term, input bit spur);
    int lat_exp;
    logic [RES_W:0] word;
    clr_cyc = -1; fin_cyc = -1; iss_cyc = -1; err_cyc = -1;
    lat_exp = 1 + 1 + (RES_W + 1) + 1;
    exp_idle();
    start = 1; num_terms = CNT_W'(n);
    tick();
    start = 0;
    exp_busy(); e_clr = 1;
    acc = '0;
    if (spur) mac_done = 1;
    tick();
    mac_done = 0; mac_res = '0; mac_carry = 0;
    for (int t = 0; t < n; t++) begin
      for (int k = 0; k < OP_W; k++) begin
        exp_busy();
        e_a = part(cur_a, opa_t[t], k);
        e_b = part(cur_b, opb_t[t], k);
        ser_a = opa_t[t][k]; ser_b = opb_t[t][k];
        if (spur && $urandom_range(3) == 0) start = 1;
        if (spur && $urandom_range(3) == 0) mac_done = 1;
        tick();
        start = 0; mac_done = 0;
      end
      cur_a = opa_t[t]; cur_b = opb_t[t];
      lat_exp += OP_W + 1 + lat_t[t];
      exp_busy(); e_ms = 1;
      if (spur) mac_done = 1;
      tick();
      mac_done = 0;
      if (t == to_term) begin
        for (int j = 0; j < TIMEOUT; j++) begin
          exp_busy();
          if (spur && j == 3) start = 1;
          tick();
          start = 0;
        end
        exp_idle(); e_err = 1;
        tick();
        exp_idle();
        tick();
        check_eq("timeout_delay", err_cyc - iss_cyc, TIMEOUT + 1);
        return;
      end
      for (int j = 0; j < lat_t[t]; j++) begin
        exp_busy();
        if (j == lat_t[t] - 1) begin
          mac_done = 1;
          acc = acc + opa_t[t] * opb_t[t];
          mac_res = acc[RES_W-1:0]; mac_carry = acc[RES_W];
        end
        tick();
        mac_done = 0;
      end
    end
    if (force_cap) begin
      mac_res = RES_W'(1); mac_carry = 1;
      word = {1'b1, RES_W'(1)};
    end else begin
      word = acc;
    end
    exp_busy();
    tick();
    for (int i = 0; i <= RES_W; i++) begin
      exp_busy(); e_sv = 1; e_so = word[i];
      if (spur && i == 7) start = 1;
      if (i == rst_drain) reset = 1;
      tick();
      start = 0;
      if (i == rst_drain) begin
        reset = 0; cur_a = '0; cur_b = '0;
        exp_idle();
        tick();
        exp_idle();
        tick();
        return;
      end
    end
    exp_busy(); e_fin = 1;
    tick();
    exp_idle();
    tick();
    check_eq("latency", fin_cyc - clr_cyc + 1, lat_exp);
  endtask

  initial begin
    reset = 1; start = 0; num_terms = '0; ser_a = 0; ser_b = 0;
    mac_done = 0; mac_res = '0; mac_carry = 0;
    cur_a = '0; cur_b = '0; acc = '0; ser_word = '0;
    ser_idx = 0; issue_cnt = 0;
    tick();
    exp_idle();
    chk_en = 1;
    tick();
    reset = 0;
    exp_idle();
    tick();

    // Single term
    opa_t[0] = 3; opb_t[0] = 5; lat_t[0] = 3;
    run_session(1, 0, -1, -1, 0);
    check_eq("single_result", ser_word, 15);
    check_eq("single_latency", fin_cyc - clr_cyc + 1, 36);

    // Two terms
    for (int t = 0; t < 2; t++) begin opa_t[t] = 255; opb_t[t] = 255; lat_t[t] = 2 + 3 * t; end
    run_session(2, 0, -1, -1, 0);
    check_eq("two_result", ser_word, 130050);

    // Max terms via num_terms = 0
    for (int t = 0; t < 16; t++) begin opa_t[t] = 255; opb_t[t] = 255; lat_t[t] = 1; end
    run_session(16, 0, -1, -1, 0);
    check_eq("max_result", ser_word, 1040400);
    check_eq("max_issues", issue_cnt, 16);

    // Forced carry word
    opa_t[0] = 1; opb_t[0] = 1; lat_t[0] = 2;
    run_session(1, 1, -1, -1, 0);
    check_eq("carry_last_bit", ser_word[RES_W], 1);
    check_eq("carry_word", ser_word, (1 << RES_W) + 1);

    // Timeout on second term
    opa_t[0] = 4; opb_t[0] = 4; lat_t[0] = 2;
    opa_t[1] = 6; opb_t[1] = 6; lat_t[1] = 2;
    run_session(2, 0, -1, 1, 0);
    check_eq("timeout_no_finish", fin_cyc, -1);

    // Completion on the final watchdog cycle
    opa_t[0] = 10; opb_t[0] = 10; lat_t[0] = TIMEOUT;
    run_session(1, 0, -1, -1, 0);
    check_eq("edge_done_result", ser_word, 100);

    // Spurious start / mac_done
    opa_t[0] = 9; opb_t[0] = 11; lat_t[0] = 4;
    opa_t[1] = 4; opb_t[1] = 6;  lat_t[1] = 2;
    run_session(2, 0, -1, -1, 1);
    check_eq("spurious_result", ser_word, 123);

    // Reset mid-drain, then a fresh session
    opa_t[0] = 100; opb_t[0] = 3; lat_t[0] = 2;
    run_session(1, 0, 5, -1, 0);
    check_eq("reset_no_finish", fin_cyc, -1);
    opa_t[0] = 2; opb_t[0] = 7; lat_t[0] = 3;
    run_session(1, 0, -1, -1, 0);
    check_eq("after_reset_result", ser_word, 14);

    // Randomized sessions
    for (int s = 0; s < 30; s++) begin
      int n, to_term, rst_drain;
      n = $urandom_range(16, 1);
      for (int t = 0; t < n; t++) begin
        opa_t[t] = OP_W'($urandom);
        opb_t[t] = OP_W'($urandom);
        lat_t[t] = ($urandom_range(9) == 0) ? TIMEOUT : $urandom_range(12, 1);
      end
      to_term   = ($urandom_range(7) == 0) ? $urandom_range(n - 1) : -1;
      rst_drain = ($urandom_range(7) == 0) ? $urandom_range(RES_W) : -1;
      run_session(n, $urandom_range(9) == 0, rst_drain, to_term, 1'($urandom));
    end

    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mac_serial_sequencer.md
Name: mac_serial_sequencer

Overview:
- Controller that sequences the 8x8 MAC datapath (operand registers, multiplier, add/accumulate) from a pin-limited serial host interface.
- Clears the accumulator, then for each of N terms deserializes operand A/B, issues a multiply-accumulate and waits for completion.
- After the last term, serializes the {carry, result} word out on one pin and pulses finish.
- Sits between chip-level io pins and the MAC datapath.

Parameters:
- OP_W, 8, operand width (bits shifted per operand)
- RES_W, 20, accumulator result width
- TIMEOUT, 64, max cycles in WAIT before abort
- CNT_W, 4, width of num_terms; value 0 means 2**CNT_W terms

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high; one clock, named clock, reset is synchronous and active-high
- start  in  1  begin session; sampled only in IDLE
- num_terms  in  CNT_W  term count, latched when start is accepted
- ser_a  in  1  operand A serial bit, LSB first
- ser_b  in  1  operand B serial bit, LSB first
- op_a  out  OP_W  operand A to datapath
- op_b  out  OP_W  operand B to datapath
- acc_clear  out  1  one-cycle accumulator clear
- mac_start  out  1  one-cycle multiply-accumulate issue
- mac_done  in  1  datapath completion, one-cycle pulse
- mac_res  in  RES_W  accumulator value
- mac_carry  in  1  accumulator carry-out
- ser_out  out  1  result serial bit, LSB first, carry last
- ser_valid  out  1  ser_out is valid this cycle
- busy  out  1  high in every state except IDLE
- finish  out  1  one-cycle session-complete pulse
- err_timeout  out  1  one-cycle abort pulse

Behaviour:
- Reset: state IDLE. All outputs 0, including op_a/op_b. All counters and shift registers cleared.
- IDLE: start=1 latches num_terms into term_rem (0 loads 2**CNT_W), then goes to CLEAR.
- CLEAR: acc_clear=1 for exactly one cycle, then SHIFT with bit_cnt=0.
- SHIFT: for OP_W cycles, each edge does op_a<={ser_a,op_a[OP_W-1:1]} and the same for op_b. Goes to ISSUE when bit_cnt==OP_W-1.
- ISSUE: mac_start=1 for one cycle. op_a/op_b stay stable from ISSUE until mac_done is seen. Then WAIT, with wd_cnt=0.
- WAIT: wd_cnt increments every cycle.
  - On mac_done: term_rem decrements; if the new value is nonzero, go to SHIFT (bit_cnt=0), else go to CAPTURE.
  - If wd_cnt reaches TIMEOUT-1 without mac_done: err_timeout=1 for one cycle and return to IDLE. finish is not asserted.
- CAPTURE: one cycle; loads a (RES_W+1)-bit shift register with {mac_carry, mac_res}. Then DRAIN.
- DRAIN: RES_W+1 cycles with ser_valid=1 and ser_out=shreg[0], shifting right each cycle. Then DONE.
- DONE: finish=1 for one cycle, then IDLE. busy drops in the same cycle as the return to IDLE.
- Latency from start accepted to finish, with L = WAIT cycles per term: 1 + N*(OP_W+1+L) + 1 + (RES_W+1) + 1.
- Ignored events:
  - start outside IDLE.
  - mac_done outside WAIT.
  - mac_done in the same cycle as mac_start (ISSUE); the datapath must respond at least one cycle later.
- Simultaneous mac_done and timeout edge: mac_done wins.
- Reset mid-session, any state: return to IDLE on the next edge with outputs zeroed; no finish and no err_timeout.
- Counter widths: bit_cnt ceil(log2(OP_W)); drain counter ceil(log2(RES_W+1)); term_rem CNT_W+1; wd_cnt ceil(log2(TIMEOUT)).

Decomposition:
- Shared package mac_pkg:
  - OP_W and RES_W defaults.
  - Typedef mac_seq_state_e {IDLE, CLEAR, SHIFT, ISSUE, WAIT, CAPTURE, DRAIN, DONE}.
  - Typedef for the {carry, result} word.
- One sub-module, mac_piso: parallel-load, right-shift serializer with load/shift/valid. Used for CAPTURE/DRAIN.

Test Plan:
- Single term: num_terms=1, A=3, B=5, bench MAC model with L=3 returning 15 → acc_clear 1 cycle; mac_start with op_a=3, op_b=5; ser_out LSB-first 21 bits = 15 then carry 0; finish 1 cycle; total latency matches the formula.
- Two terms: num_terms=2, A=B=255 twice → two mac_start pulses; serialized result 130050, carry 0.
- Max terms: num_terms=0, A=B=255 x16 → 16 issues; result 1040400, carry 0. Then model forces mac_carry=1, res=0x00001 → last ser_out bit = 1.
- Timeout: model never asserts mac_done → err_timeout pulse exactly TIMEOUT cycles after entering WAIT; back to IDLE; no finish, no ser_valid.
- Spurious inputs: start pulsed during SHIFT and DRAIN, and mac_done pulsed during SHIFT → no effect on sequence or result.
- Reset mid-DRAIN after 5 bits → next cycle all outputs 0, state IDLE; a following session with A=2, B=7 yields 14.
